// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source interrupt controller with edge/level pending, fixed priority and a REQ/SERVICE handshake to CP0.
module irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq_in,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        int_req,
  output logic [2:0]  int_id,
  input  logic        int_ack
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t      state_q;
  logic [5:0]  mask_q, mode_q, pend_q, pend_d, sync_q, prev_q, elig, clr;
  logic [2:0]  id_q, sel;
  logic        busy_q, req_q, ack_hit, eoi;
  assign elig    = pend_q & mask_q;
  assign ack_hit = state_q == REQ && int_ack;
  assign eoi     = state_q == SERVICE && we && addr == 2'd3 && data_in[0];
  assign clr     = (we && addr == 2'd2 ? data_in[5:0] : 6'd0) | (ack_hit ? 6'b1 << id_q : 6'd0);
  // Edge bits keep state with set winning over clear; level bits just follow sync.
  assign pend_d  = (mode_q & ((pend_q & ~clr) | (sync_q & ~prev_q))) | (~mode_q & sync_q);
  assign int_req = req_q;
  assign int_id  = id_q;
  always_comb begin
    sel = 3'd0;
    for (int i = 5; i >= 0; i--) if (elig[i]) sel = 3'(i);
  end
  always_comb begin
    data_out = addr == 2'd0 ? {26'd0, mask_q} :
               addr == 2'd1 ? {26'd0, mode_q} :
               addr == 2'd2 ? {26'd0, pend_q} : {28'd0, busy_q, id_q};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      sync_q  <= '0;
      prev_q  <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q <= irq_in;
      prev_q <= sync_q;
      pend_q <= pend_d;
      if (we && addr == 2'd0) mask_q <= data_in[5:0];
      if (we && addr == 2'd1) mode_q <= data_in[5:0];
      case (state_q)
        IDLE: if (|elig) begin
          id_q    <= sel;
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (int_ack) begin
          busy_q  <= 1'b1;
          req_q   <= 1'b0;
          state_q <= SERVICE;
        end else if (!elig[id_q]) begin
          id_q    <= '0;
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
        SERVICE: if (eoi) begin
          id_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have these ports: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high; clock clk.
REQ-003 irq_in  input  6  device interrupt lines; bit 0 is the timer, bits 1-5 are other devices.
REQ-004 addr  input  2 (bits [3:2])  register select: 0 MASK, 1 MODE, 2 PENDING, 3 STATUS.
REQ-005 we  input  1  register write strobe, single cycle.
REQ-006 data_in  input  32  write data.
REQ-007 data_out  output  32  combinational read of the register selected by addr.
REQ-008 int_req  output  1  interrupt request to CP0.
REQ-009 int_id  output  3  index of the requesting source; valid while int_req=1.
REQ-010 int_ack  input  1  single-cycle acknowledge from CP0 on exception entry.

Function
REQ-011 Registers SHALL be: MASK[5:0] (1 = enabled); MODE[5:0] (1 = edge, 0 = level); PENDING[5:0]; STATUS = {28'b0, busy, id[2:0]}.
REQ-012 Register bits [31:6] of MASK, MODE and PENDING SHALL read as 0 and ignore writes.
REQ-013 irq_in SHALL be registered once (sync). The previous sync value SHALL be held in a second register (prev).
REQ-014 Edge-mode source i: PENDING[i] SHALL set on the cycle after sync[i]=1 and prev[i]=0.
REQ-015 Level-mode source i: PENDING[i] SHALL equal sync[i] each cycle.
REQ-016 A write to PENDING SHALL clear each edge-mode bit written as 1 (write-1-to-clear); level-mode bits SHALL ignore the write.
REQ-017 If a set and a clear of the same edge bit occur in the same cycle, the set SHALL win.
REQ-018 Writes to MASK and MODE SHALL take effect on the next cycle. A MODE change SHALL NOT alter the current PENDING value.
REQ-019 Eligible = PENDING & MASK. The selected source SHALL be the lowest eligible index (bit 0 has the highest priority).
REQ-020 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-021 IDLE: if any source is eligible, the FSM SHALL latch the selected index into id and enter REQ. int_req SHALL go to 1 in the first REQ cycle, one cycle after eligibility is seen.
REQ-022 REQ: int_req SHALL be 1 and int_id SHALL equal the latched id, held stable until the request is acked or withdrawn.
REQ-023 REQ with int_ack=1: the FSM SHALL enter SERVICE, set busy=1 and deassert int_req the next cycle. If source id is edge-mode, PENDING[id] SHALL be cleared.
REQ-024 REQ with int_ack=0 and source id no longer eligible (masked or cleared): the FSM SHALL return to IDLE and deassert int_req the next cycle. No ack is consumed.
REQ-025 int_ack arriving in IDLE or SERVICE SHALL be ignored.
REQ-026 SERVICE: int_req SHALL stay 0 regardless of new pending sources. New edge events SHALL still be latched into PENDING.
REQ-027 SERVICE with a write to STATUS and data_in[0]=1 (EOI): the FSM SHALL clear busy and go to IDLE. A higher-priority pending source SHALL be re-arbitrated from IDLE.
REQ-028 A STATUS write with data_in[0]=0, or a STATUS write outside SERVICE, SHALL have no effect.
REQ-029 A level source still asserted after EOI SHALL be requested again, 2 cycles after the EOI write.
REQ-030 A write and an edge event on the same cycle SHALL both be processed; only the same-bit PENDING conflict of REQ-017 exists.

Reset
REQ-031 On reset=1 at a clock edge, MASK, MODE, PENDING, sync, prev, id and busy SHALL become 0, and the FSM SHALL enter IDLE.
REQ-032 During and after reset, int_req SHALL be 0 and int_id SHALL be 0. data_out SHALL read 0 for every addr.
REQ-033 Reset asserted in REQ or SERVICE SHALL abort the request. No ack or EOI is required afterwards.

Verification
REQ-034 Edge basic: MASK=0x01, MODE=0x01, pulse irq_in[0] for 1 cycle -> int_req=1 and int_id=0 three cycles after the pulse edge; int_ack -> PENDING reads 0x00 and STATUS reads 0x8; EOI -> STATUS reads 0x0.
REQ-035 Priority: MASK=0x3F, irq_in[3] and irq_in[1] rise together -> int_id=1; after ack and EOI -> int_id=3.
REQ-036 Withdraw: source 2 in REQ, write MASK=0x00 before ack -> int_req=0 next cycle, FSM in IDLE, PENDING[2] still 1 (edge mode).
REQ-037 Level re-request: MODE=0, irq_in[4] held high through ack and EOI -> int_req reasserts with int_id=4 two cycles after EOI; irq_in[4] low -> PENDING[4]=0.
REQ-038 Set/clear collision: write PENDING=0x01 on the same cycle an edge-0 event is latched -> PENDING[0] reads 1.
REQ-039 Reset mid-service: in SERVICE, assert reset -> int_req=0, STATUS=0, all registers 0, and a new edge after reset is serviced normally.
